grid_rotate_scan: RTL and testbench

Sequential, parametrised successor to the combinational maze-index rotator. On a start command it latches a new orientation, either absolute or relative to the current one, then walks every cell of a SIZE×SIZE grid in raster order. For each cell it emits the source RAM index and the rotated destination index on a valid/ready stream. It sits between the maze RAM and the frame/copy engine that rebuilds the maze in its rotated orientation.

---
 rtl/grid_rotate_scan_if.sv | 21 ++
 rtl/grid_rotate_scan.sv | 158 +++++++++++++++
 tb/tb_grid_rotate_scan.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/grid_rotate_scan_if.sv
// Output stream bundle of grid_rotate_scan: one (src, dst) index pair per beat.
// The master drives the beat and the slave drives out_ready.
interface grid_rotate_scan_if #(
    parameter int IW = 9
);
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] src_index;
    logic [IW-1:0] dst_index;
    logic          out_last;

    modport master (
        output out_valid, src_index, dst_index, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, src_index, dst_index, out_last,
        output out_ready
    );
endinterface

// File: rtl/grid_rotate_scan.sv
// Raster walk of a SIZE x SIZE grid emitting source and rotated destination indices.
// Optional horizontal flip before rotation is enabled by defining GRID_ROTATE_MIRROR_EN.
module grid_rotate_scan #(
    parameter  int SIZE = 22,
    localparam int CW   = $clog2(SIZE),
    localparam int IW   = $clog2(SIZE * SIZE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                rel,
    input  logic [1:0]          dir_in,
`ifdef GRID_ROTATE_MIRROR_EN
    input  logic                mirror,
`endif
    output logic                busy,
    output logic [1:0]          cur_dir,
    output logic                done,
    grid_rotate_scan_if.master  st
);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_SCAN = 1'b1;
    localparam logic [CW-1:0] C_MAX   = CW'(SIZE - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]    dir_q, dir_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic [IW-1:0] src_q, src_d, dst_q, dst_d;
    logic          cur_m, start_m;
    logic [CW-1:0] nx, ny;
    logic [1:0]    nd;

`ifdef GRID_ROTATE_MIRROR_EN
    logic mir_q, mir_d;
    assign cur_m   = mir_q;
    assign start_m = mirror;
`else
    assign cur_m   = 1'b0;
    assign start_m = 1'b0;
`endif

    // All arithmetic at IW bits; every c here is <= S-1 so S-1-c never wraps.
    function automatic logic [IW-1:0] dst_map(
        input logic [CW-1:0] cx,
        input logic [CW-1:0] cy,
        input logic [1:0]    d,
        input logic          m
    );
        logic [IW-1:0] s, s1, xi, yi, xp, ry;
        s  = IW'(SIZE);
        s1 = IW'(SIZE - 1);
        xi = IW'(cx);
        yi = IW'(cy);
        xp = m ? s1 - xi : xi;
        ry = s1 - yi;
        unique case (d)
            2'd0:    return yi * s + xp;
            2'd1:    return xp * s + ry;
            2'd2:    return ry * s + (s1 - xp);
            default: return (s1 - xp) * s + yi;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        src_d   = src_q;
        dst_d   = dst_q;
        nx      = x_q;
        ny      = y_q;
        nd      = rel ? dir_q + dir_in : dir_in;
`ifdef GRID_ROTATE_MIRROR_EN
        mir_d   = mir_q;
`endif
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d = ST_SCAN;
                x_d     = '0;
                y_d     = '0;
                dir_d   = nd;
                valid_d = 1'b1;
                last_d  = 1'b0;
                src_d   = '0;
                dst_d   = dst_map('0, '0, nd, start_m);
`ifdef GRID_ROTATE_MIRROR_EN
                mir_d   = mirror;
`endif
            end
        end else if (st.out_ready) begin
            if (last_q) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                done_d  = 1'b1;
                x_d     = '0;
                y_d     = '0;
            end else begin
                if (x_q == C_MAX) begin
                    nx = '0;
                    ny = y_q + 1'b1;
                end else begin
                    nx = x_q + 1'b1;
                end
                x_d    = nx;
                y_d    = ny;
                last_d = (nx == C_MAX) && (ny == C_MAX);
                src_d  = IW'(ny) * IW'(SIZE) + IW'(nx);
                dst_d  = dst_map(nx, ny, dir_q, cur_m);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dir_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
`ifdef GRID_ROTATE_MIRROR_EN
            mir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
`ifdef GRID_ROTATE_MIRROR_EN
            mir_q   <= mir_d;
`endif
        end
    end

    assign busy         = (state_q == ST_SCAN);
    assign cur_dir      = dir_q;
    assign done         = done_q;
    assign st.out_valid = valid_q;
    assign st.src_index = src_q;
    assign st.dst_index = dst_q;
    assign st.out_last  = last_q;
endmodule

// File: tb/tb_grid_rotate_scan.sv
// Randomised bench for grid_rotate_scan at SIZE=4 against a coordinate-rotation model.
// Define GRID_ROTATE_MIRROR_EN for both bench and design to cover the flip.
module tb_grid_rotate_scan;
    localparam int S  = 4;
    localparam int IW = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rel = 1'b0;
    logic [1:0] dir_in = 2'd0;
`ifdef GRID_ROTATE_MIRROR_EN
    logic       mirror = 1'b0;
`endif
    logic       busy, done;
    logic [1:0] cur_dir;

    grid_rotate_scan_if #(.IW(IW)) st ();

    grid_rotate_scan #(.SIZE(S)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .rel     (rel),
        .dir_in  (dir_in),
`ifdef GRID_ROTATE_MIRROR_EN
        .mirror  (mirror),
`endif
        .busy    (busy),
        .cur_dir (cur_dir),
        .done    (done),
        .st      (st)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int exp_src[$];
    int exp_dst[$];
    bit exp_last[$];
    int m_dir    = 0;
    bit done_exp = 0;
    int beats    = 0;
    bit chk_en   = 0;
    bit bp_mode  = 0;

    // Flip, then turn the grid clockwise d times: (col,row) -> (S-1-row, col).
    function automatic int map_cell(int src, int d, bit m);
        int x, y, t;
        x = src % S;
        y = src / S;
        if (m) x = S - 1 - x;
        for (int k = 0; k < d; k++) begin
            t = x;
            x = S - 1 - y;
            y = t;
        end
        return y * S + x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1 st.out_ready = bp_mode ? 1'($urandom % 2) : 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_vs_valid", 32'(busy), 32'(st.out_valid));
            chk("cur_dir", 32'(cur_dir), 32'(m_dir));
            chk("done", 32'(done), 32'(done_exp));
            if (done_exp) begin
                chk("beat_count", 32'(beats), 32'(S * S));
                beats = 0;
            end
            done_exp = 0;
            chk("valid", 32'(st.out_valid), 32'(exp_src.size() != 0));
            if (st.out_valid && exp_src.size() != 0) begin
                chk("src", 32'(st.src_index), 32'(exp_src[0]));
                chk("dst", 32'(st.dst_index), 32'(exp_dst[0]));
                chk("last", 32'(st.out_last), 32'(exp_last[0]));
                if (st.out_ready) begin
                    if (exp_last[0]) done_exp = 1;
                    void'(exp_src.pop_front());
                    void'(exp_dst.pop_front());
                    void'(exp_last.pop_front());
                    beats++;
                end
            end
        end
    end

    task automatic start_scan(input bit r, input int d, input bit m);
        start  = 1'b1;
        rel    = r;
        dir_in = 2'(d);
`ifdef GRID_ROTATE_MIRROR_EN
        mirror = m;
`endif
        @(posedge clk);
        m_dir = r ? (m_dir + d) % 4 : d;
        for (int i = 0; i < S * S; i++) begin
            exp_src.push_back(i);
            exp_dst.push_back(map_cell(i, m_dir, m));
            exp_last.push_back(i == S * S - 1);
        end
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && exp_src.size() == 0) return;
        end
        chk("scan_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        repeat (2) begin
            @(posedge clk);
            #1;
            start  = 1'($urandom % 2);
            rel    = 1'($urandom % 2);
            dir_in = 2'($urandom % 4);
        end
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cur_dir", 32'(cur_dir), 32'd0);
        chk("rst_valid", 32'(st.out_valid), 32'd0);
        chk("rst_last", 32'(st.out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_src", 32'(st.src_index), 32'd0);
        chk("rst_dst", 32'(st.dst_index), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        chk_en = 1;

        chk("pin_d1_s0", 32'(map_cell(0, 1, 0)), 32'd3);
        chk("pin_d1_s1", 32'(map_cell(1, 1, 0)), 32'd7);
        chk("pin_d2_s0", 32'(map_cell(0, 2, 0)), 32'd15);
        chk("pin_d2_s1", 32'(map_cell(1, 2, 0)), 32'd14);
        chk("pin_d0_s9", 32'(map_cell(9, 0, 0)), 32'd9);
        chk("pin_m_s0", 32'(map_cell(0, 0, 1)), 32'd3);
        chk("pin_m_s5", 32'(map_cell(5, 0, 1)), 32'd6);

        start_scan(0, 0, 0);
        wait_idle();
        start_scan(0, 1, 0);
        wait_idle();
        start_scan(0, 2, 0);
        wait_idle();

        start_scan(0, 3, 0);
        wait_idle();
        start_scan(1, 1, 0);
        chk("rel_wrap_0", 32'(cur_dir), 32'd0);
        wait_idle();
        start_scan(1, 3, 0);
        chk("rel_wrap_3", 32'(cur_dir), 32'd3);
        wait_idle();

        bp_mode = 1;
        repeat (4) begin
            start_scan(1'($urandom % 2), int'($urandom % 4), 0);
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (!busy) break;
                start  = 1'($urandom % 2);
                rel    = 1'($urandom % 2);
                dir_in = 2'($urandom % 4);
            end
            start = 1'b0;
            wait_idle();
        end
        bp_mode = 0;

`ifdef GRID_ROTATE_MIRROR_EN
        start_scan(0, 0, 1);
        wait_idle();
        bp_mode = 1;
        start_scan(0, int'($urandom % 4), 1);
        wait_idle();
        bp_mode = 0;
`endif

        start_scan(0, 1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        exp_src.delete();
        exp_dst.delete();
        exp_last.delete();
        done_exp = 0;
        beats    = 0;
        m_dir    = 0;
        @(negedge clk);
        chk("midrst_valid", 32'(st.out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_no_done", 32'(done), 32'd0);

        start_scan(1, 2, 0);
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
